banked_scratchpad_ram: RTL and testbench

BANKED_SCRATCHPAD_RAM -- requirements
Module: banked_scratchpad_ram

---
 rtl/banked_scratchpad_ram.sv | 158 +++++++++++++++
 tb/tb_banked_scratchpad_ram.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/banked_scratchpad_ram.sv
// Banked scratchpad RAM: NUM_BANKS parallel banks read together at one
// address, written singly or by broadcast, with a background zero-fill that
// sweeps every address of every bank. Reads are pipelined (1 or 2 cycles)
// and write-first against a same-edge write.
module banked_scratchpad_ram #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 12,
    parameter int NUM_BANKS    = 4,
    parameter int READ_LATENCY = 1,
    parameter int BANK_W       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear_req,
    output logic                            busy,
    input  logic                            read_req,
    input  logic [ADDR_WIDTH-1:0]           read_addr,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] read_data,
    output logic                            read_valid,
    input  logic                            write_req,
    input  logic [BANK_W-1:0]               write_bank,
    input  logic                            write_broadcast,
    input  logic [ADDR_WIDTH-1:0]           write_addr,
    input  logic [DATA_WIDTH-1:0]           write_data
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t                          state_q, state_d;
    logic [ADDR_WIDTH-1:0]           ptr_q, ptr_d;
    logic [1:0]                      rst_sync_q;
    logic                            rst_int;

    // Bank words are signed samples; the array comes up zeroed at configuration.
    logic signed [DATA_WIDTH-1:0]    mem_q [NUM_BANKS][DEPTH] = '{default: '0};

    logic [NUM_BANKS-1:0]            mem_we;
    logic [ADDR_WIDTH-1:0]           mem_waddr;
    logic signed [DATA_WIDTH-1:0]    mem_wdata;
    logic                            rd_accept;
    logic [NUM_BANKS*DATA_WIDTH-1:0] rd_word;
    logic                            pipe_vld;
    logic [NUM_BANKS*DATA_WIDTH-1:0] pipe_data;
    logic [NUM_BANKS*DATA_WIDTH-1:0] read_data_q;
    logic                            read_valid_q;

    // Reset asserts immediately, releases two clean edges after reset drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rst_sync_q <= 2'b11;
        else       rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
    assign rst_int = rst_sync_q[1];

    // FSM state and clear pointer registers.
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: a clear request in IDLE starts the sweep; the sweep ends after the top address.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: begin
                ptr_d = '0;
                if (clear_req) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                ptr_d = ptr_q + ADDR_WIDTH'(1);
                if (ptr_q == '1) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_CLEAR);

    // Memory port arbitration: the sweep owns every bank while clearing; host
    // traffic is accepted only in IDLE without a competing clear request.
    always_comb begin
        mem_we    = '0;
        mem_waddr = write_addr;
        mem_wdata = write_data;
        rd_accept = 1'b0;
        if (state_q == S_CLEAR) begin
            mem_we    = '1;
            mem_waddr = ptr_q;
            mem_wdata = '0;
        end else if (!clear_req && !rst_int) begin
            rd_accept = read_req;
            if (write_req) begin
                // Out-of-range bank indices never match, so such writes drop.
                for (int b = 0; b < NUM_BANKS; b++)
                    mem_we[b] = write_broadcast || (b == int'(write_bank));
            end
        end
    end

    // Bank storage; deliberately outside reset so a reset never disturbs contents.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++)
            if (mem_we[b]) mem_q[b][mem_waddr] <= mem_wdata;
    end

    // Read word with write-first bypass for banks written at the same address.
    always_comb begin
        rd_word = '0;
        for (int b = 0; b < NUM_BANKS; b++)
            rd_word[b*DATA_WIDTH +: DATA_WIDTH] =
                (mem_we[b] && (mem_waddr == read_addr)) ? mem_wdata : mem_q[b][read_addr];
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                            rd_vld_p0_q;
            logic [NUM_BANKS*DATA_WIDTH-1:0] rd_data_p0_q;

            // Stage p0: valid flag is flushed by reset.
            always_ff @(posedge clk or posedge rst_int) begin
                if (rst_int) rd_vld_p0_q <= 1'b0;
                else         rd_vld_p0_q <= rd_accept;
            end

            // Stage p0: captured read word.
            always_ff @(posedge clk) begin
                if (rd_accept) rd_data_p0_q <= rd_word;
            end

            assign pipe_vld  = rd_vld_p0_q;
            assign pipe_data = rd_data_p0_q;
        end else begin : g_lat1
            assign pipe_vld  = rd_accept;
            assign pipe_data = rd_word;
        end
    endgenerate

    // Output stage: read_data updates only on a returned read and holds otherwise.
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            read_valid_q <= 1'b0;
            read_data_q  <= '0;
        end else begin
            read_valid_q <= pipe_vld;
            if (pipe_vld) read_data_q <= pipe_data;
        end
    end

    assign read_valid = read_valid_q;
    assign read_data  = read_data_q;

endmodule

// File: tb/tb_banked_scratchpad_ram.sv
// Directed bench for banked_scratchpad_ram at 8-bit data, 16-deep banks,
// latency 2; a second 3-bank instance shares the stimulus to show dropped writes.
module tb_banked_scratchpad_ram;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear_req = 1'b0;
    logic        read_req = 1'b0;
    logic        write_req = 1'b0;
    logic        write_broadcast = 1'b0;
    logic [1:0]  write_bank = '0;
    logic [3:0]  read_addr = '0;
    logic [3:0]  write_addr = '0;
    logic [7:0]  write_data = '0;

    logic        busy, read_valid;
    logic [31:0] read_data;
    logic        busy3, read_valid3;
    logic [23:0] read_data3;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    banked_scratchpad_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_BANKS(4), .READ_LATENCY(2)) dut (
        .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy),
        .read_req(read_req), .read_addr(read_addr), .read_data(read_data), .read_valid(read_valid),
        .write_req(write_req), .write_bank(write_bank), .write_broadcast(write_broadcast),
        .write_addr(write_addr), .write_data(write_data)
    );

    banked_scratchpad_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_BANKS(3), .READ_LATENCY(2)) dut3 (
        .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy3),
        .read_req(read_req), .read_addr(read_addr), .read_data(read_data3), .read_valid(read_valid3),
        .write_req(write_req), .write_bank(write_bank), .write_broadcast(write_broadcast),
        .write_addr(write_addr), .write_data(write_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rep4(input logic [7:0] b);
        return {4{b}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] bank, input logic bcast, input logic [3:0] addr, input logic [7:0] data);
        write_req = 1'b1; write_bank = bank; write_broadcast = bcast;
        write_addr = addr; write_data = data;
        tick();
        write_req = 1'b0; write_broadcast = 1'b0;
    endtask

    task automatic rd(input logic [3:0] addr, input logic [31:0] exp, input string tag);
        read_req = 1'b1; read_addr = addr;
        tick();
        read_req = 1'b0;
        tick();
        chk({tag, "_v"}, {31'd0, read_valid}, 32'd1);
        chk({tag, "_d"}, read_data, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int stray;

        // reset state
        #2 reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (4) tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, read_valid}, 32'd0);
        chk("rst_data", read_data, 32'd0);
        chk("rst_busy3", {31'd0, busy3}, 32'd0);

        // out-of-range bank on the 3-bank instance is dropped
        wr(2'd3, 1'b0, 4'd9, 8'h55);
        wr(2'd2, 1'b0, 4'd9, 8'h22);
        read_req = 1'b1; read_addr = 4'd9;
        tick();
        read_req = 1'b0;
        tick();
        chk("nb3_valid", {31'd0, read_valid3}, 32'd1);
        chk("nb3_data", {8'd0, read_data3}, 32'h0022_0000);
        chk("nb4_data", read_data, 32'h5522_0000);

        // single-bank write then latency-2 read with hold
        wr(2'd2, 1'b0, 4'd5, 8'h7F);
        read_req = 1'b1; read_addr = 4'd5;
        tick();
        read_req = 1'b0;
        chk("lat_early", {31'd0, read_valid}, 32'd0);
        tick();
        chk("lat_valid", {31'd0, read_valid}, 32'd1);
        chk("lat_data", read_data, 32'h007F_0000);
        tick();
        chk("hold_valid", {31'd0, read_valid}, 32'd0);
        chk("hold_data", read_data, 32'h007F_0000);

        // broadcast write, back-to-back reads
        wr(2'd0, 1'b1, 4'd3, 8'h80);
        read_req = 1'b1; read_addr = 4'd3;
        tick();
        read_addr = 4'd4;
        tick();
        read_req = 1'b0;
        chk("b2b0_v", {31'd0, read_valid}, 32'd1);
        chk("b2b0_d", read_data, 32'h8080_8080);
        tick();
        chk("b2b1_v", {31'd0, read_valid}, 32'd1);
        chk("b2b1_d", read_data, 32'h0000_0000);
        tick();
        chk("b2b_end", {31'd0, read_valid}, 32'd0);

        // write-first on same address
        wr(2'd0, 1'b1, 4'd7, 8'hA5);
        write_req = 1'b1; write_bank = 2'd0; write_broadcast = 1'b0;
        write_addr = 4'd7; write_data = 8'h11;
        read_req = 1'b1; read_addr = 4'd7;
        tick();
        write_req = 1'b0; read_req = 1'b0;
        tick();
        chk("wf_v", {31'd0, read_valid}, 32'd1);
        chk("wf_d", read_data, 32'hA5A5_A511);
        rd(4'd7, 32'hA5A5_A511, "wf_after");

        // fill, then a full clear with traffic during busy
        for (int a = 0; a < 16; a++) wr(2'd0, 1'b1, 4'(a), 8'(8'h30 + a));
        read_req = 1'b1; read_addr = 4'd2;
        tick();
        clear_req = 1'b1; read_addr = 4'd3;
        write_req = 1'b1; write_broadcast = 1'b1; write_addr = 4'd15; write_data = 8'hEE;
        tick();
        clear_req = 1'b0;
        read_addr = 4'd0; write_addr = 4'd0;
        chk("clr_busy", {31'd0, busy}, 32'd1);
        chk("preclr_v", {31'd0, read_valid}, 32'd1);
        chk("preclr_d", read_data, rep4(8'h32));
        busy_cnt = 1;
        stray = 0;
        for (int n = 0; n < 40 && busy; n++) begin
            tick();
            if (read_valid) stray++;
            if (busy) busy_cnt++;
        end
        read_req = 1'b0; write_req = 1'b0; write_broadcast = 1'b0;
        chk("busy_len", busy_cnt, 32'd16);
        chk("busy_stray_rd", stray, 32'd0);
        chk("busy_done", {31'd0, busy}, 32'd0);
        for (int a = 0; a < 16; a++) rd(4'(a), 32'd0, $sformatf("clr_rd%0d", a));

        // reset in the middle of a clear leaves it partial
        for (int a = 0; a < 16; a++) wr(2'd0, 1'b1, 4'(a), 8'(8'h40 + a));
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (6) tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_valid", {31'd0, read_valid}, 32'd0);
        chk("mid_rst_data", read_data, 32'd0);
        #2 reset = 1'b0;
        repeat (4) tick();
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        for (int a = 0; a < 16; a++)
            rd(4'(a), (a < 6) ? 32'd0 : rep4(8'(8'h40 + a)), $sformatf("part_rd%0d", a));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
